run_check_ctrl: RTL
===================

RUN_CHECK_CTRL -- requirements
Module: run_check_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of memory words, chk_data and q_b.
REQ-002 Parameter ADDR_WIDTH, default 16: width of memory port-B address and chk_addr.
REQ-003 Parameter RUN_CYCLES, default 300: number of DUT clock-enabled cycles per run, at least 1.
REQ-004 Parameter RST_CYCLES, default 1: number of cycles dut_rst is held high before the run, at least 1.
REQ-005 Parameter CNT_WIDTH, default 16: width of run_cnt and fail_count.
REQ-006 Port clk, input, 1: the single clock for the block.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: one-cycle pulse that begins a reset-run-check sequence.
REQ-009 Port dut_rst, output, 1: reset driven to the datapath under test.
REQ-010 Port dut_en, output, 1: clock enable driven to the datapath under test.
REQ-011 Port chk_valid / chk_ready, input / output, 1 each: check-stream handshake.
REQ-012 Port chk_addr, input, ADDR_WIDTH: memory address to check.
REQ-013 Port chk_data, input, DATA_WIDTH: expected word at that address.
REQ-014 Port chk_last, input, 1: marks the final check entry.
REQ-015 Port addr_b / we_b / data_b, output, ADDR_WIDTH / 1 / DATA_WIDTH: BRAM port-B drive.
REQ-016 Port q_b, input, DATA_WIDTH: BRAM port-B read data, registered with 1-cycle latency.
REQ-017 Port busy / done / pass, output, 1 each: sequence status.
REQ-018 Port run_cnt / fail_count, output, CNT_WIDTH each: elapsed run cycles and mismatch count.
REQ-019 Port first_fail_addr, output, ADDR_WIDTH: address of the first mismatch.

Function
REQ-020 The FSM SHALL have the states IDLE, DRST, RUN, ISSUE, WAIT and DONE.
REQ-021 IDLE: on start, clear run_cnt, fail_count and first_fail_addr, then go to DRST.
REQ-022 DRST: hold dut_rst=1 and dut_en=0 for exactly RST_CYCLES cycles, then go to RUN.
REQ-023 RUN: hold dut_en=1 and increment run_cnt each cycle; after exactly RUN_CYCLES enabled cycles, leave dut_en=0 and go to ISSUE.
REQ-024 ISSUE: chk_ready=1, and only in this state; on chk_valid&&chk_ready, drive addr_b=chk_addr, latch chk_data and chk_last, go to WAIT.
REQ-025 WAIT: chk_ready=0; compare q_b to the latched expected word.
REQ-026 On a WAIT mismatch: increment fail_count, saturating at all-ones.
REQ-027 On the first WAIT mismatch only: capture first_fail_addr.
REQ-028 Leaving WAIT: go to DONE if the latched last flag is set, otherwise return to ISSUE.
REQ-029 Throughput SHALL be one check per 2 cycles.
REQ-030 DONE: done=1 and pass=(fail_count==0) are held; a new start restarts from DRST with results cleared.
REQ-031 we_b SHALL be constant 0 and data_b constant 0: the block never writes memory.
REQ-032 busy SHALL be 1 in DRST, RUN, ISSUE and WAIT, else 0.
REQ-033 start SHALL be ignored while busy=1.
REQ-034 ISSUE with chk_valid low SHALL wait indefinitely, with no timeout.
REQ-035 chk_valid with chk_ready low SHALL be neither consumed nor lost.
REQ-036 addr_b SHALL hold its last value outside ISSUE.

Reset
REQ-037 On rst (synchronous, active-high): state=IDLE; dut_rst=1, so the DUT is held reset while this block is reset; dut_en=0, chk_ready=0, busy=0, done=0, pass=0, all counters and first_fail_addr=0, addr_b=0.
REQ-038 In IDLE after reset, dut_rst SHALL return to 0.
REQ-039 rst mid-sequence from any state SHALL abort to IDLE in the next cycle with the reset values above, with no pending check completed.

Structure
REQ-040 A shared package SHALL hold the FSM state enum and the default RUN_CYCLES/RST_CYCLES constants.
REQ-041 A single sub-module, cycle_counter, SHALL be used for both the DRST and RUN cycle counts: load, enable and terminal-count flag, parametrised by width.
REQ-042 The compare and check handshake SHALL remain in the top module.

Verification
REQ-043 rst, then start with RUN_CYCLES=300, RST_CYCLES=1 -> dut_rst high 1 cycle, dut_en high exactly 300 cycles, run_cnt=300.
REQ-044 Memory preloaded {0x40:2000, 0x41:3000, 0x42:4000}; stream those 3 checks, last on 0x42 -> done=1, pass=1, fail_count=0, 6 cycles from first accept to done.
REQ-045 Same memory; expect 0x41=3001 and 0x42=4001 -> pass=0, fail_count=2, first_fail_addr=0x41.
REQ-046 chk_valid deasserted for 5 cycles between checks and start pulsed mid-RUN -> no lost or duplicated check, start ignored, sequence unchanged.
REQ-047 rst asserted during WAIT -> IDLE next cycle, fail_count=0, done=0; a following start runs cleanly.
REQ-048 CNT_WIDTH=2 with 5 mismatching checks -> fail_count saturates at 3.

Source files
------------

// File: rtl/run_check_ctrl_pkg.sv
// Shared types and defaults for the run/check controller.
// Holds the FSM state enum and the default run/reset cycle counts.
package run_check_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_RUN,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int DEF_RUN_CYCLES = 300;
    localparam int DEF_RST_CYCLES = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/run_check_ctrl_if.sv
// Check-stream handshake plus BRAM port-B bundle.
// master: stream source / memory side; slave: the controller.
interface run_check_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic                  chk_valid;
    logic                  chk_ready;
    logic [ADDR_WIDTH-1:0] chk_addr;
    logic [DATA_WIDTH-1:0] chk_data;
    logic                  chk_last;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output chk_valid, chk_addr, chk_data, chk_last, q_b,
        input  chk_ready, addr_b, we_b, data_b
    );

    modport slave (
        input  chk_valid, chk_addr, chk_data, chk_last, q_b,
        output chk_ready, addr_b, we_b, data_b
    );
endinterface

// File: rtl/run_check_ctrl_cycle_counter.sv
// Loadable down-counter with terminal-count flag (tc when count is 0).
// Ports: clk, rst (sync high), load/load_val, en, tc.
module cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - WIDTH'(1);
    end

    assign tc = (count == '0);
endmodule

// File: rtl/run_check_ctrl.sv
// Resets and runs a datapath for a fixed number of cycles, then checks
// memory words from a stream. Ports: clk, rst, start, bus (check stream and
// BRAM port B), dut_rst/dut_en, busy/done/pass, run_cnt, fail_count,
// first_fail_addr.
module run_check_ctrl
    import run_check_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    run_check_ctrl_if.slave       bus,
    output logic                  dut_rst,
    output logic                  dut_en,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  run_cnt,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);
    localparam int TW = $clog2(max_int(RUN_CYCLES, RST_CYCLES) + 1);

    state_t                state, state_nx;
    logic                  rst_hold;
    logic                  go, accept, mismatch;
    logic                  tc, cnt_load, cnt_en;
    logic [TW-1:0]         load_val;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  last_q;

    assign go       = start && (state == S_IDLE || state == S_DONE);
    assign accept   = (state == S_ISSUE) && bus.chk_valid;
    assign mismatch = (state == S_WAIT) && (bus.q_b != exp_q);

    // One counter serves both phases: loaded for DRST on start,
    // reloaded for RUN on the DRST terminal count.
    assign cnt_load = go || (state == S_DRST && tc);
    assign cnt_en   = (state == S_DRST) || (state == S_RUN);
    assign load_val = go ? TW'(RST_CYCLES - 1) : TW'(RUN_CYCLES - 1);

    cycle_counter #(.WIDTH(TW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_DRST;
            S_DRST:  if (tc) state_nx = S_RUN;
            S_RUN:   if (tc) state_nx = S_ISSUE;
            S_ISSUE: if (bus.chk_valid) state_nx = S_WAIT;
            S_WAIT:  state_nx = last_q ? S_DONE : S_ISSUE;
            S_DONE:  if (start) state_nx = S_DRST;
            default: state_nx = S_IDLE;
        endcase
    end

    // rst_hold keeps the datapath in reset while this block is in reset.
    always_comb begin
        dut_rst       = rst_hold || (state == S_DRST);
        dut_en        = (state == S_RUN);
        bus.chk_ready = (state == S_ISSUE);
        busy          = (state == S_DRST) || (state == S_RUN) ||
                        (state == S_ISSUE) || (state == S_WAIT);
        done          = (state == S_DONE);
        pass          = (state == S_DONE) && (fail_count == '0);
    end

    // Address goes to the BRAM in the accept cycle so q_b is ready in WAIT.
    assign bus.addr_b = accept ? bus.chk_addr : addr_q;
    assign bus.we_b   = 1'b0;
    assign bus.data_b = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_hold        <= 1'b1;
            run_cnt         <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            addr_q          <= '0;
            exp_q           <= '0;
            last_q          <= 1'b0;
        end else begin
            rst_hold <= 1'b0;
            if (go) begin
                run_cnt         <= '0;
                fail_count      <= '0;
                first_fail_addr <= '0;
            end
            if (state == S_RUN)
                run_cnt <= run_cnt + CNT_WIDTH'(1);
            if (accept) begin
                addr_q <= bus.chk_addr;
                exp_q  <= bus.chk_data;
                last_q <= bus.chk_last;
            end
            if (mismatch) begin
                if (!(&fail_count))
                    fail_count <= fail_count + CNT_WIDTH'(1);
                if (fail_count == '0)
                    first_fail_addr <= addr_q;
            end
        end
    end
endmodule
